// File: rtl/vc_arbiter.sv
// Round-robin scheduler between four input VC FIFOs and four output FIFOs.
// Pops one input FIFO per cycle and routes each returned word by its destination bits.
module vc_arbiter #(
  parameter int BITNUMBER = 6,
  parameter int UMBRAL_W  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic [UMBRAL_W-1:0]    umbral_in,
  input  logic [3:0]             in_empty,
  input  logic [3:0]             in_valid,
  input  logic [4*BITNUMBER-1:0] in_data,
  input  logic [3:0]             out_pause,
  output logic [3:0]             pop,
  output logic [3:0]             out_push,
  output logic [BITNUMBER-1:0]   out_data,
  output logic [UMBRAL_W-1:0]    umbral_out,
  output logic                   active,
  output logic [7:0]             word_count,
  output logic                   arb_error
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  state_e                state_q;
  logic [1:0]            rr_ptr_q;
  logic [1:0]            last_q;
  logic                  last_vld_q;
  logic                  active_q;
  logic [UMBRAL_W-1:0]   umbral_q;
  logic [3:0]            push_q;
  logic [BITNUMBER-1:0]  data_q;
  logic [7:0]            count_q;
  logic                  err_q;

  logic                  stall;
  logic [3:0]            eligible;
  logic                  grant_vld;
  logic [1:0]            grant_idx;
  logic [1:0]            cand;
  logic                  pop_en;
  logic [BITNUMBER-1:0]  rt_word;
  logic [1:0]            rt_dest;
  logic                  rt_multi;

  assign stall = |out_pause;

  // The FIFO granted last cycle still shows non-empty because its flag lags a cycle.
  assign eligible = ~in_empty & (last_vld_q ? ~(4'b0001 << last_q) : 4'b1111);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign pop_en = reset && (state_q == S_ACTIVE) && grant_vld && !stall && !init;
  assign pop    = pop_en ? (4'b0001 << grant_idx) : 4'b0000;

  // Lowest valid index wins when several FIFOs return data together.
  always_comb begin
    rt_word = '0;
    for (int i = 3; i >= 0; i--) begin
      if (in_valid[i]) rt_word = in_data[i*BITNUMBER +: BITNUMBER];
    end
  end

  assign rt_dest  = rt_word[BITNUMBER-1 -: 2];
  assign rt_multi = |(in_valid & (in_valid - 4'd1));

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      rr_ptr_q   <= 2'd3;
      last_q     <= 2'd0;
      last_vld_q <= 1'b0;
      active_q   <= 1'b0;
      umbral_q   <= '0;
    end else begin
      if (pop_en) begin
        rr_ptr_q   <= grant_idx;
        last_q     <= grant_idx;
        last_vld_q <= 1'b1;
      end else begin
        last_vld_q <= 1'b0;
      end

      if (state_q == S_INIT) umbral_q <= umbral_in;

      if (init) begin
        state_q  <= S_INIT;
        active_q <= 1'b0;
      end else begin
        case (state_q)
          S_INIT: begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
          end
          S_IDLE: begin
            if ((|(~in_empty)) && !stall) begin
              state_q  <= S_ACTIVE;
              active_q <= 1'b1;
            end
          end
          S_ACTIVE: begin
            if (!grant_vld || stall) begin
              state_q  <= S_IDLE;
              active_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= S_INIT;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Routing ignores the FSM so words already requested are delivered during stall or init.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_q  <= 4'b0000;
      data_q  <= '0;
      count_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      if (|in_valid) begin
        push_q  <= 4'b0001 << rt_dest;
        data_q  <= rt_word;
        count_q <= count_q + 8'd1;
      end else begin
        push_q  <= 4'b0000;
      end
      if (rt_multi) err_q <= 1'b1;
    end
  end

  assign out_push   = push_q;
  assign out_data   = data_q;
  assign umbral_out = umbral_q;
  assign active     = active_q;
  assign word_count = count_q;
  assign arb_error  = err_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter: directed vector table, mid-operation reset,
// then randomized traffic compared against a behavioural scheduler model.
module tb_vc_arbiter;

  localparam int BN = 6;
  localparam int UW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [UW-1:0] umbral_in;
  logic [3:0]    in_empty;
  logic [3:0]    in_valid;
  logic [4*BN-1:0] in_data;
  logic [3:0]    out_pause;
  logic [3:0]    pop;
  logic [3:0]    out_push;
  logic [BN-1:0] out_data;
  logic [UW-1:0] umbral_out;
  logic          active;
  logic [7:0]    word_count;
  logic          arb_error;

  int n_cmp = 0;
  int n_err = 0;

  vc_arbiter #(.BITNUMBER(BN), .UMBRAL_W(UW)) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .umbral_in  (umbral_in),
    .in_empty   (in_empty),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_pause  (out_pause),
    .pop        (pop),
    .out_push   (out_push),
    .out_data   (out_data),
    .umbral_out (umbral_out),
    .active     (active),
    .word_count (word_count),
    .arb_error  (arb_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic i_init, input logic [UW-1:0] i_umb, input logic [3:0] i_emp,
                       input logic [3:0] i_vld, input logic [4*BN-1:0] i_dat, input logic [3:0] i_pause);
    init      = i_init;
    umbral_in = i_umb;
    in_empty  = i_emp;
    in_valid  = i_vld;
    in_data   = i_dat;
    out_pause = i_pause;
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_INIT = 0, M_IDLE = 1, M_ACTIVE = 2;
  int          m_mode, m_ptr, m_last, m_cnt;
  logic [3:0]  m_push;
  logic [5:0]  m_data;
  logic        m_err;
  logic [2:0]  m_umb;

  task automatic model_reset();
    m_mode = M_INIT; m_ptr = 3; m_last = -1; m_cnt = 0;
    m_push = 0; m_data = 0; m_err = 0; m_umb = 0;
  endtask

  function automatic logic [3:0] model_pop();
    int idx;
    if (!reset || m_mode != M_ACTIVE || out_pause != 0 || init) return 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (!in_empty[idx] && idx != m_last) return 4'(1 << idx);
    end
    return 4'b0000;
  endfunction

  task automatic model_step();
    logic [3:0] p;
    int g, lo, w;
    bit any_elig;
    p = model_pop();
    g = -1;
    for (int i = 0; i < 4; i++) if (p[i]) g = i;
    any_elig = 0;
    for (int i = 0; i < 4; i++) if (!in_empty[i] && i != m_last) any_elig = 1;
    if (in_valid != 0) begin
      lo = 0;
      for (int i = 3; i >= 0; i--) if (in_valid[i]) lo = i;
      w = int'((in_data >> (BN * lo)) & 24'h3F);
      m_push = 4'(1 << (w / 16));
      m_data = 6'(w);
      m_cnt  = (m_cnt + 1) % 256;
      if ($countones(in_valid) > 1) m_err = 1;
    end else begin
      m_push = 0;
    end
    if (m_mode == M_INIT) m_umb = umbral_in;
    if (init) m_mode = M_INIT;
    else if (m_mode == M_INIT) m_mode = M_IDLE;
    else if (m_mode == M_IDLE) begin
      if (in_empty != 4'hF && out_pause == 0) m_mode = M_ACTIVE;
    end else if (!any_elig || out_pause != 0) m_mode = M_IDLE;
    if (g >= 0) begin m_ptr = g; m_last = g; end
    else m_last = -1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        init;
    logic [2:0]  umb;
    logic [3:0]  emp;
    logic [3:0]  vld;
    logic [23:0] dat;
    logic [3:0]  pause;
    logic [3:0]  e_pop;
    logic [3:0]  e_push;
    logic [5:0]  e_data;
    logic        e_act;
    logic [2:0]  e_umb;
    logic [7:0]  e_cnt;
    logic        e_err;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          init umb emp  vld  dat          pause pop  push data act umb cnt err
    vecs[0]  = '{1, 3, 4'hF, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h00, 0, 0, 0, 0};
    vecs[1]  = '{1, 3, 4'hF, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h00, 0, 3, 0, 0};
    vecs[2]  = '{0, 3, 4'hF, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h00, 0, 3, 0, 0};
    vecs[3]  = '{0, 3, 4'hF, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h00, 0, 3, 0, 0};
    vecs[4]  = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h00, 0, 3, 0, 0};
    vecs[5]  = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h0, 4'h1, 4'h0, 6'h00, 1, 3, 0, 0};
    vecs[6]  = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h0, 4'h2, 4'h0, 6'h00, 1, 3, 0, 0};
    vecs[7]  = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h0, 4'h4, 4'h0, 6'h00, 1, 3, 0, 0};
    vecs[8]  = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h0, 4'h8, 4'h0, 6'h00, 1, 3, 0, 0};
    vecs[9]  = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h0, 4'h1, 4'h0, 6'h00, 1, 3, 0, 0};
    vecs[10] = '{0, 3, 4'hB, 4'h0, 24'h0,       4'h0, 4'h4, 4'h0, 6'h00, 1, 3, 0, 0};
    vecs[11] = '{0, 3, 4'hB, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h00, 1, 3, 0, 0};
    vecs[12] = '{0, 3, 4'hB, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h00, 0, 3, 0, 0};
    vecs[13] = '{0, 3, 4'hB, 4'h0, 24'h0,       4'h0, 4'h4, 4'h0, 6'h00, 1, 3, 0, 0};
    vecs[14] = '{0, 3, 4'hF, 4'h2, 24'h000940,  4'h0, 4'h0, 4'h0, 6'h00, 1, 3, 0, 0};
    vecs[15] = '{0, 3, 4'hF, 4'h0, 24'h0,       4'h0, 4'h0, 4'h4, 6'h25, 0, 3, 1, 0};
    vecs[16] = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h25, 0, 3, 1, 0};
    vecs[17] = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h0, 4'h8, 4'h0, 6'h25, 1, 3, 1, 0};
    vecs[18] = '{0, 3, 4'h0, 4'h8, 24'h1C0000,  4'h1, 4'h0, 4'h0, 6'h25, 1, 3, 1, 0};
    vecs[19] = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h1, 4'h0, 4'h1, 6'h07, 0, 3, 2, 0};
    vecs[20] = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h07, 0, 3, 2, 0};
    vecs[21] = '{0, 3, 4'h0, 4'h0, 24'h0,       4'h0, 4'h1, 4'h0, 6'h07, 1, 3, 2, 0};
    vecs[22] = '{0, 3, 4'hF, 4'h3, 24'h0007F1,  4'h0, 4'h0, 4'h0, 6'h07, 1, 3, 2, 0};
    vecs[23] = '{0, 3, 4'hF, 4'h0, 24'h0,       4'h0, 4'h0, 4'h8, 6'h31, 0, 3, 3, 1};
    vecs[24] = '{1, 5, 4'hF, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h31, 0, 3, 3, 1};
    vecs[25] = '{1, 5, 4'hF, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h31, 0, 3, 3, 1};
    vecs[26] = '{0, 5, 4'hF, 4'h0, 24'h0,       4'h0, 4'h0, 4'h0, 6'h31, 0, 5, 3, 1};

    reset = 1'b0;
    drive(1'b1, 3'd3, 4'hF, 4'h0, '0, 4'h0);
    #12;
    check("rst_pop",   32'(pop),        32'h0);
    check("rst_push",  32'(out_push),   32'h0);
    check("rst_data",  32'(out_data),   32'h0);
    check("rst_umb",   32'(umbral_out), 32'h0);
    check("rst_act",   32'(active),     32'h0);
    check("rst_cnt",   32'(word_count), 32'h0);
    check("rst_err",   32'(arb_error),  32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b1;
      drive(vecs[i].init, vecs[i].umb, vecs[i].emp, vecs[i].vld, vecs[i].dat, vecs[i].pause);
      #1;
      check($sformatf("v%0d_pop", i),  32'(pop),        32'(vecs[i].e_pop));
      check($sformatf("v%0d_push", i), 32'(out_push),   32'(vecs[i].e_push));
      check($sformatf("v%0d_data", i), 32'(out_data),   32'(vecs[i].e_data));
      check($sformatf("v%0d_act", i),  32'(active),     32'(vecs[i].e_act));
      check($sformatf("v%0d_umb", i),  32'(umbral_out), 32'(vecs[i].e_umb));
      check($sformatf("v%0d_cnt", i),  32'(word_count), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d_err", i),  32'(arb_error),  32'(vecs[i].e_err));
    end

    // Reset asserted mid-stream clears everything at once and suppresses later pushes.
    @(negedge clk);
    drive(1'b0, 3'd5, 4'h0, 4'h1, 24'h00002A, 4'h0);
    #1;
    check("mr_idle_pop", 32'(pop), 32'h0);
    @(negedge clk);
    #1;
    check("mr_pop",  32'(pop),        32'h2);
    check("mr_push", 32'(out_push),   32'h4);
    check("mr_cnt",  32'(word_count), 32'h4);
    check("mr_act",  32'(active),     32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mr_rst_pop",  32'(pop),        32'h0);
    check("mr_rst_push", 32'(out_push),   32'h0);
    check("mr_rst_data", 32'(out_data),   32'h0);
    check("mr_rst_cnt",  32'(word_count), 32'h0);
    check("mr_rst_err",  32'(arb_error),  32'h0);
    check("mr_rst_umb",  32'(umbral_out), 32'h0);
    check("mr_rst_act",  32'(active),     32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("mr_hold_push", 32'(out_push),   32'h0);
      check("mr_hold_pop",  32'(pop),        32'h0);
      check("mr_hold_cnt",  32'(word_count), 32'h0);
    end

    // Randomized traffic against the model, starting from a fresh reset release.
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] v;
      int r;
      @(negedge clk);
      if (c == 0) reset = 1'b1;
      r = $urandom_range(0, 99);
      if (r < 40)      v = 4'h0;
      else if (r < 95) v = 4'(1 << $urandom_range(0, 3));
      else             v = 4'($urandom);
      drive(($urandom_range(0, 99) < 3) || (c < 2),
            3'($urandom),
            4'($urandom),
            v,
            24'($urandom),
            ($urandom_range(0, 99) < 15) ? 4'(1 << $urandom_range(0, 3)) : 4'h0);
      #1;
      check("rnd_pop",  32'(pop),        32'(model_pop()));
      check("rnd_push", 32'(out_push),   32'(m_push));
      check("rnd_data", 32'(out_data),   32'(m_data));
      check("rnd_act",  32'(active),     32'(m_mode == M_ACTIVE));
      check("rnd_umb",  32'(umbral_out), 32'(m_umb));
      check("rnd_cnt",  32'(word_count), 32'(m_cnt));
      check("rnd_err",  32'(arb_error),  32'(m_err));
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
